dc_ipu_filter_cubic_apply: RTL and testbench

Bicubic convolution stage of the IPU filter path. It sits directly downstream of the cubic weight generator and consumes a 4x4 texel neighbourhood with 4 horizontal and 4 vertical signed weights. It computes a separable 4x4 weighted sum per colour channel, rounds and clamps the result, and emits one interpolated pixel per accepted input. It is a 3-stage enable-stalled pipeline using the same clr/valid-chain discipline as the rest of the filter path.

---
 rtl/dc_ipu_filter_pkg.sv | 32 +++
 rtl/dc_ipu_filter_cubic_apply_if.sv | 25 ++
 rtl/dc_ipu_filter_cubic_dot4.sv | 39 +++
 rtl/dc_ipu_pipe_valid_chain.sv | 26 ++
 rtl/dc_ipu_filter_cubic_apply.sv | 140 ++++++++++++++
 tb/tb_dc_ipu_filter_cubic_apply.sv | 296 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/dc_ipu_filter_pkg.sv
// Shared helpers for the IPU filter path: datapath width calculations and
// result clamp classification.
package dc_ipu_filter_pkg;

    typedef enum logic [1:0] {
        CLAMP_NONE = 2'b00,
        CLAMP_LOW  = 2'b01,
        CLAMP_HIGH = 2'b10
    } clamp_e;

    function automatic int channels(input int rgb_width, input int channel_width);
        return rgb_width / channel_width;
    endfunction

    // Three guard bits cover the 4-tap sum plus the zero-extended channel sign bit.
    function automatic int h_width(input int channel_width, input int weight_width);
        return channel_width + weight_width + 3;
    endfunction

    function automatic int v_width(input int channel_width, input int weight_width);
        return h_width(channel_width, weight_width) + weight_width + 2;
    endfunction

    function automatic clamp_e clamp_kind(input logic signed [63:0] r, input int channel_width);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< channel_width) - 64'sd1;
        if (r < 64'sd0) return CLAMP_LOW;
        if (r > max_v) return CLAMP_HIGH;
        return CLAMP_NONE;
    endfunction

endpackage

// File: rtl/dc_ipu_filter_cubic_apply_if.sv
// Beat interface of the bicubic apply stage: 4x4 texel neighbourhood and
// separable weights in, one interpolated pixel out.
interface dc_ipu_filter_cubic_apply_if #(
    parameter int RGB_WIDTH    = 24,
    parameter int WEIGHT_WIDTH = 10
);
    logic                           in_valid;
    logic                           in_ready;
    logic [RGB_WIDTH-1:0]           in_texel_matrix [4][4];
    logic signed [WEIGHT_WIDTH-1:0] in_weights_x [4];
    logic signed [WEIGHT_WIDTH-1:0] in_weights_y [4];
    logic                           out_valid;
    logic                           out_ready;
    logic [RGB_WIDTH-1:0]           out_pixel;

    modport master (
        output in_valid, in_texel_matrix, in_weights_x, in_weights_y, out_ready,
        input  in_ready, out_valid, out_pixel
    );

    modport slave (
        input  in_valid, in_texel_matrix, in_weights_x, in_weights_y, out_ready,
        output in_ready, out_valid, out_pixel
    );
endinterface

// File: rtl/dc_ipu_filter_cubic_dot4.sv
// Registered 4-tap signed dot product. OUT_WIDTH must hold the full exact sum
// (A_WIDTH + B_WIDTH + 2 bits is always enough).
module dc_ipu_filter_cubic_dot4 #(
    parameter int A_WIDTH   = 9,
    parameter int B_WIDTH   = 10,
    parameter int OUT_WIDTH = 21
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        i_en,
    input  logic signed [A_WIDTH-1:0]   i_a [4],
    input  logic signed [B_WIDTH-1:0]   i_b [4],
    output logic signed [OUT_WIDTH-1:0] o_sum
);
    logic signed [OUT_WIDTH-1:0] w_prod [4];
    logic signed [OUT_WIDTH-1:0] w_sum;
    logic signed [OUT_WIDTH-1:0] r_sum;

    for (genvar n = 0; n < 4; n++) begin : g_prod
        assign w_prod[n] = OUT_WIDTH'(i_a[n]) * OUT_WIDTH'(i_b[n]);
    end

    always_comb begin
        w_sum = '0;
        for (int n = 0; n < 4; n++) begin
            w_sum = w_sum + w_prod[n];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= w_sum;
        end
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/dc_ipu_pipe_valid_chain.sv
// Pipeline valid-chain cell: shifts beat valids along with the enable,
// synchronous clear has priority over the enable. LENGTH must be >= 2.
module dc_ipu_pipe_valid_chain #(
    parameter int LENGTH = 3
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic              i_valid,
    output logic [LENGTH-1:0] o_valid
);
    logic [LENGTH-1:0] r_valid;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_en) begin
            r_valid <= {r_valid[LENGTH-2:0], i_valid};
        end
    end

    assign o_valid = r_valid;
endmodule

// File: rtl/dc_ipu_filter_cubic_apply.sv
// Bicubic apply: separable 4x4 weighted sum per channel, round, clamp.
// Optional clamp statistics counter: DC_IPU_FILTER_CUBIC_CLAMP_STATS_EN.
module dc_ipu_filter_cubic_apply
    import dc_ipu_filter_pkg::*;
#(
    parameter int RGB_WIDTH          = 24,
    parameter int CHANNEL_WIDTH      = 8,
    parameter int WEIGHT_WIDTH       = 10,
    parameter int WEIGHT_FRACT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        i_clr,
    dc_ipu_filter_cubic_apply_if.slave  bus,
    output logic [15:0]                 o_clamp_count
);
    localparam int CHANNELS = channels(RGB_WIDTH, CHANNEL_WIDTH);
    localparam int H_WIDTH  = h_width(CHANNEL_WIDTH, WEIGHT_WIDTH);
    localparam int V_WIDTH  = v_width(CHANNEL_WIDTH, WEIGHT_WIDTH);
    localparam int SHIFT    = 2 * WEIGHT_FRACT_WIDTH;
    localparam logic signed [63:0] ROUND_HALF = 64'sd1 <<< (SHIFT - 1);

    logic                            w_en;
    logic                            w_load;
    logic [2:0]                      w_valid;
    logic signed [CHANNEL_WIDTH:0]   w_tex [CHANNELS][4][4];
    logic signed [H_WIDTH-1:0]       w_h [CHANNELS][4];
    logic signed [V_WIDTH-1:0]       w_v [CHANNELS];
    logic signed [63:0]              w_r [CHANNELS];
    clamp_e                          w_kind [CHANNELS];
    logic [RGB_WIDTH-1:0]            w_pixel;
    logic signed [WEIGHT_WIDTH-1:0]  r_wy [4];
    logic [RGB_WIDTH-1:0]            r_pixel;

    assign w_en         = bus.out_ready;
    assign bus.in_ready = bus.out_ready;
    // A beat being flushed must not disturb the held output pixel.
    assign w_load       = w_en & w_valid[1] & ~i_clr;

    dc_ipu_pipe_valid_chain #(.LENGTH(3)) u_valid_chain (
        .clk     (clk),
        .nreset  (nreset),
        .i_clr   (i_clr),
        .i_en    (w_en),
        .i_valid (bus.in_valid & bus.in_ready),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wy <= '{default: '0};
        end else if (w_en) begin
            r_wy <= bus.in_weights_y;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        for (genvar i = 0; i < 4; i++) begin : g_row
            for (genvar j = 0; j < 4; j++) begin : g_col
                assign w_tex[k][i][j] =
                    $signed({1'b0, bus.in_texel_matrix[i][j][k*CHANNEL_WIDTH +: CHANNEL_WIDTH]});
            end

            dc_ipu_filter_cubic_dot4 #(
                .A_WIDTH   (CHANNEL_WIDTH + 1),
                .B_WIDTH   (WEIGHT_WIDTH),
                .OUT_WIDTH (H_WIDTH)
            ) u_horz (
                .clk    (clk),
                .nreset (nreset),
                .i_en   (w_en),
                .i_a    (w_tex[k][i]),
                .i_b    (bus.in_weights_x),
                .o_sum  (w_h[k][i])
            );
        end

        dc_ipu_filter_cubic_dot4 #(
            .A_WIDTH   (H_WIDTH),
            .B_WIDTH   (WEIGHT_WIDTH),
            .OUT_WIDTH (V_WIDTH)
        ) u_vert (
            .clk    (clk),
            .nreset (nreset),
            .i_en   (w_en),
            .i_a    (w_h[k]),
            .i_b    (r_wy),
            .o_sum  (w_v[k])
        );

        // Arithmetic shift after adding one half: rounds half toward +inf.
        assign w_r[k]    = (64'(w_v[k]) + ROUND_HALF) >>> SHIFT;
        assign w_kind[k] = clamp_kind(w_r[k], CHANNEL_WIDTH);
        assign w_pixel[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
            (w_kind[k] == CLAMP_LOW)  ? '0 :
            (w_kind[k] == CLAMP_HIGH) ? '1 : w_r[k][CHANNEL_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pixel <= '0;
        end else if (w_load) begin
            r_pixel <= w_pixel;
        end
    end

    assign bus.out_pixel = r_pixel;
    assign bus.out_valid = w_valid[2];

`ifdef DC_IPU_FILTER_CUBIC_CLAMP_STATS_EN
    logic [15:0] r_clamp_count;
    logic [15:0] w_clamp_inc;
    logic [16:0] w_clamp_sum;

    always_comb begin
        w_clamp_inc = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_kind[k] != CLAMP_NONE) begin
                w_clamp_inc = w_clamp_inc + 16'd1;
            end
        end
    end

    assign w_clamp_sum = {1'b0, r_clamp_count} + {1'b0, w_clamp_inc};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_clamp_count <= '0;
        end else if (i_clr) begin
            r_clamp_count <= '0;
        end else if (w_load) begin
            r_clamp_count <= w_clamp_sum[16] ? 16'hFFFF : w_clamp_sum[15:0];
        end
    end

    assign o_clamp_count = r_clamp_count;
`else
    assign o_clamp_count = '0;
`endif
endmodule

// File: tb/tb_dc_ipu_filter_cubic_apply.sv
// Scoreboard bench for dc_ipu_filter_cubic_apply: directed beats push expected
// pixels, a negedge monitor pops and compares whenever a pixel is presented.
module tb_dc_ipu_filter_cubic_apply;
    typedef logic [23:0]        tex_t [4][4];
    typedef logic signed [9:0]  w4_t [4];
    typedef struct {
        logic [23:0] pix;
        int          due;
    } exp_t;

`ifdef DC_IPU_FILTER_CUBIC_CLAMP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] clamp_count;

    int   errors = 0;
    int   checks = 0;
    int   en_cyc = 0;
    int   outs_seen = 0;
    int   pushes = 0;
    bit   push_en = 1'b1;
    exp_t sb [$];
    tex_t t;
    w4_t  wx;
    w4_t  wy;

    always #5 clk = ~clk;

    dc_ipu_filter_cubic_apply_if #(.RGB_WIDTH(24), .WEIGHT_WIDTH(10)) bus ();

    dc_ipu_filter_cubic_apply dut (
        .clk           (clk),
        .nreset        (nreset),
        .i_clr         (clr),
        .bus           (bus),
        .o_clamp_count (clamp_count)
    );

    function automatic logic [15:0] exp_clamps(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fill(input logic [23:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[i][j] = v;
    endtask

    task automatic send(input logic [23:0] exp_pix);
        int   guard;
        exp_t e;
        guard = 0;
        bus.in_texel_matrix = t;
        bus.in_weights_x    = wx;
        bus.in_weights_y    = wy;
        bus.in_valid        = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (push_en) begin
                    e.pix = exp_pix;
                    e.due = en_cyc + 3;
                    sb.push_back(e);
                    pushes++;
                end
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat not accepted within %0d cycles", guard);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs still outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    always @(posedge clk) begin
        if (nreset && bus.out_ready) en_cyc <= en_cyc + 1;
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (nreset && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pixel %h expected no output", bus.out_pixel);
            end else if (bus.out_ready) begin
                e = sb.pop_front();
                outs_seen++;
                chk("out_pixel", 64'(bus.out_pixel), 64'(e.pix));
                chk("latency", 64'(en_cyc), 64'(e.due));
            end else begin
                chk("stall_hold", 64'(bus.out_pixel), 64'(sb[0].pix));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        fill(24'h0);
        wx = '{default: '0};
        wy = '{default: '0};
        bus.in_texel_matrix = t;
        bus.in_weights_x    = wx;
        bus.in_weights_y    = wy;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pixel", 64'(bus.out_pixel), 64'd0);
        chk("rst_clamp_count", 64'(clamp_count), 64'd0);
        bus.out_ready = 1'b0;
        #1;
        chk("in_ready_low", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("in_ready_high", 64'(bus.in_ready), 64'd1);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // identity
        fill(24'hFFFFFF);
        t[1][1] = 24'h123456;
        wx = '{10'sd0, 10'sd256, 10'sd0, 10'sd0};
        wy = '{10'sd0, 10'sd256, 10'sd0, 10'sd0};
        send(24'h123456);
        drain();
        chk("clamp_identity", 64'(clamp_count), 64'd0);

        // flat field
        fill(24'h808080);
        wx = '{-10'sd16, 10'sd144, 10'sd144, -10'sd16};
        wy = '{-10'sd16, 10'sd144, 10'sd144, -10'sd16};
        send(24'h808080);

        // per-channel blend 0.25/0.75
        fill(24'hFFFFFF);
        t[1][1] = 24'h102030;
        t[1][2] = 24'h305070;
        wx = '{10'sd0, 10'sd64, 10'sd192, 10'sd0};
        wy = '{10'sd0, 10'sd256, 10'sd0, 10'sd0};
        send(24'h284460);

        // rounding 1.5 -> 2
        fill(24'hFFFFFF);
        t[1][0] = 24'h000000;
        t[1][1] = 24'h010101;
        t[1][2] = 24'h020202;
        t[1][3] = 24'h000000;
        wx = '{10'sd0, 10'sd128, 10'sd128, 10'sd0};
        send(24'h020202);
        drain();
        chk("clamp_none", 64'(clamp_count), 64'd0);

        // undershoot clamp
        for (int i = 0; i < 4; i++) begin
            t[i][0] = 24'hFFFFFF;
            t[i][1] = 24'h000000;
            t[i][2] = 24'h000000;
            t[i][3] = 24'hFFFFFF;
        end
        wx = '{-10'sd32, 10'sd160, 10'sd160, -10'sd32};
        wy = '{10'sd0, 10'sd256, 10'sd0, 10'sd0};
        send(24'h000000);
        drain();
        chk("clamp_under", 64'(clamp_count), 64'(exp_clamps(3)));

        // overshoot clamp
        fill(24'hFFFFFF);
        wx = '{10'sd0, 10'sd511, 10'sd0, 10'sd0};
        send(24'hFFFFFF);
        drain();
        chk("clamp_over", 64'(clamp_count), 64'(exp_clamps(6)));

        // extreme negative weights: positive product, no internal overflow
        wx = '{default: -10'sd512};
        wy = '{default: -10'sd512};
        send(24'hFFFFFF);
        drain();
        chk("clamp_extreme", 64'(clamp_count), 64'(exp_clamps(9)));

        // back-pressure: 8 distinct identity beats with a 5-cycle stall
        fill(24'hFFFFFF);
        wx = '{10'sd0, 10'sd256, 10'sd0, 10'sd0};
        wy = '{10'sd0, 10'sd256, 10'sd0, 10'sd0};
        seen0 = outs_seen;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    t[1][1] = {8'(16 * n + 1), 8'(3 * n + 7), 8'(240 - n)};
                    send(t[1][1]);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_outputs", 64'(outs_seen - seen0), 64'd8);

        // flush with beats in flight; third beat accepted alongside clr
        push_en = 1'b0;
        t[1][1] = 24'hAAAAAA;
        send(24'h0);
        send(24'h0);
        clr = 1'b1;
        send(24'h0);
        clr = 1'b0;
        chk("clr_valid_next", 64'(bus.out_valid), 64'd0);
        push_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("clr_valid_later", 64'(bus.out_valid), 64'd0);
        chk("clr_clamp_count", 64'(clamp_count), 64'd0);
        t[1][1] = 24'hABCDEF;
        send(24'hABCDEF);
        drain();

        // asynchronous reset mid-stream
        push_en = 1'b0;
        t[1][1] = 24'h555555;
        send(24'h0);
        send(24'h0);
        nreset = 1'b0;
        #1;
        chk("nrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("nrst_out_pixel", 64'(bus.out_pixel), 64'd0);
        chk("nrst_clamp_count", 64'(clamp_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        push_en = 1'b1;
        @(posedge clk);
        #1;
        t[1][1] = 24'h13579B;
        send(24'h13579B);
        drain();
        repeat (6) @(posedge clk);
        #1;

        chk("total_outputs", 64'(outs_seen), 64'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
